// File: rtl/regfile_sb_pkg.sv
// Shared constants for the scoreboarded register file: default widths,
// the hard-wired zero register address and the pending-counter ceiling.
package regfile_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int ADDR_W_DEF   = 5;
  localparam int NUM_RD_DEF   = 2;
  localparam bit ZERO_REG_DEF = 1'b1;
  localparam bit BYPASS_DEF   = 1'b1;
  localparam int CNT_W_DEF    = 2;

  localparam int ZERO_ADDR = 0;

  // Largest number of writes that may be in flight to one register.
  function automatic int cnt_max(input int cnt_w);
    return (1 << cnt_w) - 1;
  endfunction

endpackage

// File: rtl/regfile_sb_counter.sv
// Pending-write counter for one register: counts issued-but-not-retired
// writes, saturates at the ceiling and never wraps below zero.
module sb_counter
  import regfile_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  input  logic             flush,
  output logic [CNT_W-1:0] cnt,
  output logic             full,
  output logic             nonzero
);

  localparam logic [CNT_W-1:0] MAX = CNT_W'(cnt_max(CNT_W));

  logic [CNT_W-1:0] r_cnt;
  logic             w_dec_eff;

  // A write-back only retires something when a write is actually pending.
  assign w_dec_eff = dec && (r_cnt != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (flush) begin
      r_cnt <= inc ? CNT_W'(1) : '0;
    end else if (inc && !w_dec_eff && (r_cnt != MAX)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else if (w_dec_eff && !inc) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign cnt     = r_cnt;
  assign full    = (r_cnt == MAX);
  assign nonzero = (r_cnt != '0);

endmodule

// File: rtl/regfile_sb.sv
// Register file with combinational read ports, one write-back port,
// optional write-to-read bypass and a per-register pending-write scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter bit ZERO_REG = ZERO_REG_DEF,
  parameter bit BYPASS   = BYPASS_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_addr,
  output logic                     issue_ready,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     flush,
  input  logic [ADDR_W-1:0]        dbg_addr,
  output logic [DATA_W-1:0]        dbg_data
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(ZERO_ADDR);

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [CNT_W-1:0]  w_cnt  [DEPTH];
  logic [DEPTH-1:0]  w_full;
  logic [DEPTH-1:0]  w_nonzero;
  logic [DEPTH-1:0]  w_inc;
  logic [DEPTH-1:0]  w_dec;
  logic              w_wr_legal;
  logic              w_issue_zero;
  logic              w_issue_acc;

  assign w_wr_legal   = wr_en && !(ZERO_REG && (wr_addr == ZADDR));
  assign w_issue_zero = ZERO_REG && (issue_addr == ZADDR);

  // A full counter can still take an issue when a write-back retires one slot.
  assign issue_ready  = w_issue_zero || !w_full[issue_addr]
                        || (w_wr_legal && (wr_addr == issue_addr));
  assign w_issue_acc  = issue_en && issue_ready && !w_issue_zero;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_legal) begin
      r_regs[wr_addr] <= wr_data;
    end
  end

  assign dbg_data = r_regs[dbg_addr];

  genvar gi;

  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_sb
      assign w_inc[gi] = w_issue_acc && (issue_addr == ADDR_W'(gi));
      assign w_dec[gi] = w_wr_legal && (wr_addr == ADDR_W'(gi));

      sb_counter #(
        .CNT_W   (CNT_W)
      ) u_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc     (w_inc[gi]),
        .dec     (w_dec[gi]),
        .flush   (flush),
        .cnt     (w_cnt[gi]),
        .full    (w_full[gi]),
        .nonzero (w_nonzero[gi])
      );
    end
  endgenerate

  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] w_addr;
      logic              w_zero;
      logic              w_fwd;
      logic              w_retire;

      assign w_addr = rd_addr[gi*ADDR_W +: ADDR_W];
      assign w_zero = ZERO_REG && (w_addr == ZADDR);
      assign w_fwd  = BYPASS && w_wr_legal && (wr_addr == w_addr);

      assign rd_data[gi*DATA_W +: DATA_W] = w_zero ? '0 :
                                            w_fwd  ? wr_data : r_regs[w_addr];

      // The last outstanding write landing now clears busy early, unless a
      // new issue to the same register re-arms it in the same cycle.
      assign w_retire = w_fwd && (w_cnt[w_addr] == CNT_W'(1))
                        && !(w_issue_acc && (issue_addr == w_addr));
      assign rd_busy[gi] = !w_zero && w_nonzero[w_addr] && !w_retire;
    end
  endgenerate

endmodule
